hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32I core: IF, ID, EX, MEM, WB.
- Consumes the instruction decoder's outputs for the instruction currently in ID.
- Tracks in-flight destination registers in EX, MEM and WB.
- Produces operand-forwarding selects, load-use stalls, taken-branch flushes and the halt/drain sequence that stops the core.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline: tracks in-flight destinations in EX/MEM/WB
// and produces forwarding selects, load-use stalls, branch flushes and the halt/drain sequence.
module hazard_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_srcreg1_num,
    input  logic [REG_W-1:0] id_srcreg2_num,
    input  logic [REG_W-1:0] id_dstreg_num,
    input  logic             id_reg_we,
    input  logic             id_is_load,
    input  logic             id_is_halt,
    input  logic             ex_branch_taken,
    input  logic             mem_stall,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic             flush_if,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic             halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        logic             we;
        logic             load;
        logic             halt;
    } entry_t;

    // Stage index 0 = EX, 1 = MEM, 2 = WB (youngest first).
    localparam int N_STAGE = 3;

    entry_t ent_reg  [N_STAGE];
    entry_t ent_next [N_STAGE];
    state_t state_reg;
    state_t state_next;

    logic [N_STAGE-1:0] match1;
    logic [N_STAGE-1:0] match2;
    logic               lu;
    logic               br;
    logic               issue;

    generate
        for (genvar gi = 0; gi < N_STAGE; gi++) begin : g_match
            assign match1[gi] = ent_reg[gi].valid & ent_reg[gi].we &
                                (id_srcreg1_num != '0) & (ent_reg[gi].dst == id_srcreg1_num);
            assign match2[gi] = ent_reg[gi].valid & ent_reg[gi].we &
                                (id_srcreg2_num != '0) & (ent_reg[gi].dst == id_srcreg2_num);
        end
    endgenerate

    function automatic logic [1:0] pick_youngest(input logic [N_STAGE-1:0] m);
        logic [1:0] sel;
        sel = 2'd0;
        if (m[0]) begin
            sel = 2'd1;
        end else if (m[1]) begin
            sel = 2'd2;
        end else if (m[2]) begin
            sel = 2'd3;
        end
        return sel;
    endfunction

    assign fwd1_sel = pick_youngest(match1);
    assign fwd2_sel = pick_youngest(match2);

    assign br     = ex_branch_taken;
    assign lu     = id_valid & ent_reg[0].load & (match1[0] | match2[0]);
    assign halted = (state_reg == HALTED);

    // Only an instruction that survives flush, load-use and drain enters EX.
    assign issue  = id_valid & ~br & ~lu & (state_reg == RUN);

    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_bubble = 1'b0;
        flush_if  = 1'b0;
        if (mem_stall) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
        end else if (br) begin
            flush_if  = 1'b1;
            ex_bubble = 1'b1;
        end else if (lu || (state_reg != RUN)) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
        end
    end

    always_comb begin
        ent_next[0] = ent_reg[0];
        ent_next[1] = ent_reg[1];
        ent_next[2] = ent_reg[2];
        state_next  = state_reg;
        if (!mem_stall) begin
            ent_next[2]       = ent_reg[1];
            ent_next[1]       = ent_reg[0];
            ent_next[0].valid = issue;
            ent_next[0].dst   = id_dstreg_num;
            // A halt never writes back, so it can never be a forwarding source.
            ent_next[0].we    = id_reg_we & ~id_is_halt;
            ent_next[0].load  = id_is_load;
            ent_next[0].halt  = id_is_halt;
            case (state_reg)
                RUN: begin
                    if (issue && id_is_halt) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (ent_reg[2].valid && ent_reg[2].halt) begin
                        state_next = HALTED;
                    end
                end
                HALTED: begin
                    state_next = HALTED;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_STAGE; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    ent_reg[gi] <= '0;
                end else begin
                    ent_reg[gi] <= ent_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a history-based model checked every cycle, plus literal
// expectations taken from hand-worked instruction sequences.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_srcreg1_num;
    logic [4:0] id_srcreg2_num;
    logic [4:0] id_dstreg_num;
    logic       id_reg_we;
    logic       id_is_load;
    logic       id_is_halt;
    logic       ex_branch_taken;
    logic       mem_stall;
    logic       if_stall;
    logic       id_stall;
    logic       ex_bubble;
    logic       flush_if;
    logic [1:0] fwd1_sel;
    logic [1:0] fwd2_sel;
    logic       halted;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_srcreg1_num  (id_srcreg1_num),
        .id_srcreg2_num  (id_srcreg2_num),
        .id_dstreg_num   (id_dstreg_num),
        .id_reg_we       (id_reg_we),
        .id_is_load      (id_is_load),
        .id_is_halt      (id_is_halt),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .if_stall        (if_stall),
        .id_stall        (id_stall),
        .ex_bubble       (ex_bubble),
        .flush_if        (flush_if),
        .fwd1_sel        (fwd1_sel),
        .fwd2_sel        (fwd2_sel),
        .halted          (halted)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model: history of what was issued into EX, most recent first (distance 1, 2, 3).
    typedef struct {
        bit v;
        int dst;
        bit we;
        bit ld;
        bit hl;
    } rec_t;

    rec_t hist[$];
    rec_t new_r;
    int   mode       = 0;  // 0 running, 1 draining, 2 halted
    int   retire_cnt = 0;  // unstalled edges left before the issued halt retires

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int exp_fwd(input int s);
        for (int d = 0; d < hist.size(); d++) begin
            if (hist[d].v && hist[d].we && s != 0 && hist[d].dst == s) return d + 1;
        end
        return 0;
    endfunction

    function automatic bit exp_lu();
        if (hist.size() == 0 || !id_valid) return 0;
        if (!(hist[0].v && hist[0].ld && hist[0].we)) return 0;
        return (id_srcreg1_num != 0 && hist[0].dst == int'(id_srcreg1_num)) ||
               (id_srcreg2_num != 0 && hist[0].dst == int'(id_srcreg2_num));
    endfunction

    task automatic model_step();
        if (rst) begin
            hist.delete();
            mode       = 0;
            retire_cnt = 0;
        end else if (!mem_stall) begin
            new_r.v   = id_valid && !ex_branch_taken && !exp_lu() && mode == 0;
            new_r.dst = int'(id_dstreg_num);
            new_r.we  = id_reg_we && !id_is_halt;
            new_r.ld  = id_is_load;
            new_r.hl  = id_is_halt;
            if (mode == 1) begin
                retire_cnt--;
                if (retire_cnt == 0) mode = 2;
            end
            hist.push_front(new_r);
            if (hist.size() > 3) void'(hist.pop_back());
            if (new_r.v && new_r.hl) begin
                mode       = 1;
                retire_cnt = 3;
            end
        end
    endtask

    task automatic compare();
        int e_st, e_bub, e_fl;
        e_st = 0; e_bub = 0; e_fl = 0;
        if (mem_stall) begin
            e_st = 1;
        end else if (ex_branch_taken) begin
            e_bub = 1; e_fl = 1;
        end else if (exp_lu() || mode != 0) begin
            e_st = 1; e_bub = 1;
        end
        chk("if_stall", int'(if_stall), e_st);
        chk("id_stall", int'(id_stall), e_st);
        chk("ex_bubble", int'(ex_bubble), e_bub);
        chk("flush_if", int'(flush_if), e_fl);
        chk("halted", int'(halted), (mode == 2) ? 1 : 0);
        if (e_st == 0) begin
            chk("fwd1_sel", int'(fwd1_sel), exp_fwd(int'(id_srcreg1_num)));
            chk("fwd2_sel", int'(fwd2_sel), exp_fwd(int'(id_srcreg2_num)));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare();
        end
    end

    // One clock cycle: the edge consumes the previous inputs, then new ID/control inputs apply.
    task automatic cyc(input int v, input int s1, input int s2, input int d, input int we,
                       input int ld, input int hl, input int br, input int ms, input int r);
        @(posedge clk);
        model_step();
        #1;
        id_valid        = v[0];
        id_srcreg1_num  = s1[4:0];
        id_srcreg2_num  = s2[4:0];
        id_dstreg_num   = d[4:0];
        id_reg_we       = we[0];
        id_is_load      = ld[0];
        id_is_halt      = hl[0];
        ex_branch_taken = br[0];
        mem_stall       = ms[0];
        rst             = r[0];
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ins(input int s1, input int s2, input int d, input int ld);
        cyc(1, s1, s2, d, 1, ld, 0, 0, 0, 0);
    endtask

    task automatic halt_ins();
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_srcreg1_num = '0; id_srcreg2_num = '0;
        id_dstreg_num = '0; id_reg_we = 1'b0; id_is_load = 1'b0; id_is_halt = 1'b0;
        ex_branch_taken = 1'b0; mem_stall = 1'b0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_en = 1;
        idle(1);
        chk("rst_if_stall", int'(if_stall), 0);
        chk("rst_ex_bubble", int'(ex_bubble), 0);
        chk("rst_flush_if", int'(flush_if), 0);
        chk("rst_fwd1", int'(fwd1_sel), 0);
        chk("rst_halted", int'(halted), 0);

        // add x5,x1,x2 then sub x6,x5,x5 at distances 1..4
        ins(1, 2, 5, 0); ins(5, 5, 6, 0);
        chk("dist1_fwd1", int'(fwd1_sel), 1); chk("dist1_fwd2", int'(fwd2_sel), 1);
        idle(3); ins(1, 2, 5, 0); ins(0, 0, 0, 0); ins(5, 5, 6, 0);
        chk("dist2_fwd1", int'(fwd1_sel), 2); chk("dist2_fwd2", int'(fwd2_sel), 2);
        idle(3); ins(1, 2, 5, 0); ins(0, 0, 0, 0); ins(0, 0, 0, 0); ins(5, 5, 6, 0);
        chk("dist3_fwd1", int'(fwd1_sel), 3); chk("dist3_fwd2", int'(fwd2_sel), 3);
        idle(3); ins(1, 2, 5, 0); ins(0, 0, 0, 0); ins(0, 0, 0, 0); ins(0, 0, 0, 0);
        ins(5, 5, 6, 0);
        chk("dist4_fwd1", int'(fwd1_sel), 0); chk("dist4_fwd2", int'(fwd2_sel), 0);

        // lw x7,0(x1) ; add x8,x7,x3
        idle(3); ins(1, 0, 7, 1); ins(7, 3, 8, 0);
        chk("lu_if_stall", int'(if_stall), 1);
        chk("lu_id_stall", int'(id_stall), 1);
        chk("lu_ex_bubble", int'(ex_bubble), 1);
        ins(7, 3, 8, 0);
        chk("lu_after_stall", int'(if_stall), 0);
        chk("lu_after_fwd1", int'(fwd1_sel), 2);
        chk("lu_after_fwd2", int'(fwd2_sel), 0);

        // x0 never forwards or stalls; youngest of two writers wins
        idle(3); ins(0, 0, 0, 0); ins(0, 0, 9, 0);
        chk("x0_fwd1", int'(fwd1_sel), 0); chk("x0_stall", int'(if_stall), 0);
        ins(1, 0, 0, 1); ins(0, 0, 9, 0);
        chk("x0_load_stall", int'(if_stall), 0);
        idle(3); ins(1, 0, 4, 0); ins(1, 0, 4, 0); ins(4, 4, 10, 0);
        chk("youngest_fwd1", int'(fwd1_sel), 1); chk("youngest_fwd2", int'(fwd2_sel), 1);

        // taken branch over a pending load-use pair, then over a halt in ID
        idle(3); ins(1, 0, 7, 1); cyc(1, 7, 3, 8, 1, 0, 0, 1, 0, 0);
        chk("br_flush_if", int'(flush_if), 1);
        chk("br_ex_bubble", int'(ex_bubble), 1);
        chk("br_if_stall", int'(if_stall), 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("br_halt_flush", int'(flush_if), 1);
        idle(1);
        chk("br_halt_run_stall", int'(if_stall), 0);
        chk("br_halt_run_halted", int'(halted), 0);

        // mem_stall outranks a branch and freezes the load in EX
        idle(3); ins(1, 0, 7, 1); cyc(1, 7, 3, 8, 1, 0, 0, 1, 1, 0);
        chk("ms_if_stall", int'(if_stall), 1);
        chk("ms_ex_bubble", int'(ex_bubble), 0);
        chk("ms_flush_if", int'(flush_if), 0);
        ins(7, 3, 8, 0);
        chk("ms_held_lu", int'(ex_bubble), 1);
        ins(7, 3, 8, 0);
        chk("ms_held_fwd1", int'(fwd1_sel), 2);

        // halt enters EX at edge N; halted after edge N+3
        idle(3); halt_ins();
        idle(1);
        chk("drain_stall", int'(if_stall), 1); chk("drain_halted_n1", int'(halted), 0);
        idle(2);
        chk("drain_halted_n3", int'(halted), 0);
        idle(1);
        chk("drain_halted", int'(halted), 1); chk("halted_stall", int'(id_stall), 1);

        // same drain with two mem_stall cycles: halted two cycles later
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2); halt_ins();
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        chk("ms_drain_halted_late", int'(halted), 0);
        idle(1);
        chk("ms_drain_halted", int'(halted), 1);

        // reset while draining with valid entries
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2); ins(1, 2, 5, 0); halt_ins();
        cyc(1, 5, 5, 6, 1, 0, 0, 0, 0, 1);
        chk("pre_rst_stall", int'(if_stall), 1);
        ins(5, 5, 6, 0);
        chk("mid_rst_halted", int'(halted), 0);
        chk("mid_rst_if_stall", int'(if_stall), 0);
        chk("mid_rst_ex_bubble", int'(ex_bubble), 0);
        chk("mid_rst_flush_if", int'(flush_if), 0);
        chk("mid_rst_fwd1", int'(fwd1_sel), 0);
        chk("mid_rst_fwd2", int'(fwd2_sel), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
